// File: rtl/ysyx_2022040010_if_axi_fetch_if.sv
// AXI4 read-address / read-data channel bundle used by the instruction-fetch master.
//   master : the fetch unit (drives AR request and R ready)
//   slave  : the crossbar / memory side (drives AR ready and R beat)
interface ysyx_2022040010_if_axi_fetch_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );
endinterface

// File: rtl/ysyx_2022040010_if_axi_fetch.sv
// Instruction-fetch AXI4 read master between the IF stage and the AXI crossbar.
// Issues single-beat 64-bit reads, keeps the last beat in a hold register and
// serves the 32-bit instruction for the current PC from it.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   isram_e      : fetch enable from IF
//   isram_addr   : fetch PC (4-byte aligned)
//   flush        : branch redirect, discards any in-flight fetch
//   isram_rdata  : instruction for isram_addr (RST_INST while nothing is held)
//   isram_valid  : isram_rdata is valid for the current isram_addr
//   fetch_err    : one-cycle pulse after a non-OKAY beat that was kept
//   stallreq_if  : isram_e & ~isram_valid
//   axi          : AR/R channels, master modport
//
// Build option
//   IFETCH_PAIR_EN : hold match uses addr[63:3], so the second instruction of
//                    a fetched beat hits without a new read. Undefined: addr[63:2].
module ysyx_2022040010_if_axi_fetch #(
  parameter logic [3:0]  AXI_ID   = 4'h0,
  parameter logic [31:0] RST_INST = 32'h0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   isram_e,
  input  logic [63:0]                            isram_addr,
  input  logic                                   flush,
  output logic [31:0]                            isram_rdata,
  output logic                                   isram_valid,
  output logic                                   fetch_err,
  output logic                                   stallreq_if,
  ysyx_2022040010_if_axi_fetch_if.master         axi
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e      state_q;
  logic        hold_v_q;
  logic [63:2] hold_addr_q;
  logic [63:0] hold_data_q;
  logic [63:2] req_addr_q;
  logic        drop_q;
  logic        ar_valid_q;
  logic [63:0] ar_addr_q;
  logic        r_ready_q;
  logic        fetch_err_q;

  logic match;
  logic hit;
  logic beat;
  logic keep;

  always_comb begin
`ifdef IFETCH_PAIR_EN
    match = (hold_addr_q[63:3] == isram_addr[63:3]);
`else
    match = (hold_addr_q[63:2] == isram_addr[63:2]);
`endif
  end

  assign hit         = hold_v_q & match;
  assign isram_valid = isram_e & hit;
  assign stallreq_if = isram_e & ~isram_valid;
  assign isram_rdata = !hold_v_q     ? RST_INST :
                       isram_addr[2] ? hold_data_q[63:32] : hold_data_q[31:0];
  assign fetch_err   = fetch_err_q;

  assign beat = (state_q == StR) & axi.r_valid & r_ready_q;
  // A flush arriving on the beat cycle discards the beat as well.
  assign keep = beat & ~drop_q & ~flush;

  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_id    = AXI_ID;
  assign axi.ar_len   = 8'h00;
  assign axi.ar_size  = 3'b011;
  assign axi.ar_burst = 2'b01;
  assign axi.r_ready  = r_ready_q;

  // Single outstanding read with len=0: r_id and r_last carry no information.
  logic unused_bits;
  assign unused_bits = ^{isram_addr[1:0], axi.r_last, axi.r_id, hold_addr_q[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      req_addr_q  <= '0;
      drop_q      <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= keep & (axi.r_resp != 2'b00);
      if (flush) hold_v_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (isram_e && !hit && !flush) begin
            ar_addr_q  <= {isram_addr[63:3], 3'b000};
            req_addr_q <= isram_addr[63:2];
            ar_valid_q <= 1'b1;
            state_q    <= StAr;
          end
        end
        StAr: begin
          // ar_valid is never retracted once raised; a flush only marks the beat.
          if (flush) drop_q <= 1'b1;
          if (axi.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StR;
          end
        end
        StR: begin
          if (flush) drop_q <= 1'b1;
          if (beat) begin
            r_ready_q <= 1'b0;
            drop_q    <= 1'b0;
            state_q   <= StIdle;
            if (keep) begin
              hold_v_q    <= 1'b1;
              hold_addr_q <= req_addr_q;
              hold_data_q <= axi.r_data;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_if_axi_fetch.sv
module tb_ysyx_2022040010_if_axi_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        isram_e = 1'b0;
  logic [63:0] isram_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] isram_rdata;
  logic        isram_valid;
  logic        fetch_err;
  logic        stallreq_if;

  int checks = 0;
  int failures = 0;

  // Slave controls
  logic        sl_rst = 1'b1;
  logic        ar_ready_en = 1'b1;
  logic        r_stall = 1'b0;
  logic [1:0]  slave_resp = 2'b00;
  logic        pending;
  logic [63:0] pend_data;
  logic [1:0]  pend_resp;
  int          ar_cnt;

  always #5 clk = ~clk;

  ysyx_2022040010_if_axi_fetch_if bus ();

  ysyx_2022040010_if_axi_fetch #(
    .AXI_ID   (4'h0),
    .RST_INST (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .isram_e     (isram_e),
    .isram_addr  (isram_addr),
    .flush       (flush),
    .isram_rdata (isram_rdata),
    .isram_valid (isram_valid),
    .fetch_err   (fetch_err),
    .stallreq_if (stallreq_if),
    .axi         (bus.master)
  );

  function automatic logic [63:0] mem(input logic [63:0] a);
    case (a)
      64'h8000_0000: mem = 64'h0000_0413_0000_0093;
      64'h8000_0040: mem = 64'h1111_2222_3333_4444;
      64'h8000_0100: mem = 64'hAAAA_BBBB_CCCC_DDDD;
      64'h8000_0200: mem = 64'hDEAD_BEEF_0BAD_F00D;
      default:       mem = 64'h0;
    endcase
  endfunction

  // Memory-side model: answers an accepted AR with one beat, next cycle unless r_stall.
  assign bus.ar_ready = ar_ready_en;
  assign bus.r_data   = pend_data;
  assign bus.r_resp   = pend_resp;
  assign bus.r_last   = 1'b1;
  assign bus.r_id     = 4'h0;

  always_ff @(posedge clk) begin
    if (sl_rst) begin
      bus.r_valid <= 1'b0;
      pending     <= 1'b0;
      pend_data   <= '0;
      pend_resp   <= 2'b00;
      ar_cnt      <= 0;
    end else begin
      if (bus.r_valid && bus.r_ready) bus.r_valid <= 1'b0;
      if (bus.ar_valid && bus.ar_ready) begin
        ar_cnt    <= ar_cnt + 1;
        pend_data <= mem(bus.ar_addr);
        pend_resp <= slave_resp;
        if (r_stall) pending <= 1'b1;
        else bus.r_valid <= 1'b1;
      end else if (pending && !r_stall) begin
        pending     <= 1'b0;
        bus.r_valid <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    logic done;
    done = isram_valid;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      #1;
      done = isram_valid;
    end
    check(tag, {63'b0, isram_valid}, 64'd1);
  endtask

  int ar_base;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    sl_rst = 1'b0;
    #1;
    check("rst_ar_valid", {63'b0, bus.ar_valid}, 64'd0);
    check("rst_r_ready", {63'b0, bus.r_ready}, 64'd0);
    check("rst_isram_valid", {63'b0, isram_valid}, 64'd0);
    check("rst_fetch_err", {63'b0, fetch_err}, 64'd0);
    check("rst_rdata", {32'b0, isram_rdata}, 64'h0);

    // Test 1: zero-wait miss at 0x8000_0000
    tick();
    isram_e = 1'b1;
    isram_addr = 64'h8000_0000;
    #1;
    check("t1_c0_stall", {63'b0, stallreq_if}, 64'd1);
    check("t1_c0_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t1_c1_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    check("t1_c1_ar_addr", bus.ar_addr, 64'h8000_0000);
    check("t1_c1_ar_id", {60'b0, bus.ar_id}, 64'h0);
    check("t1_c1_ar_len", {56'b0, bus.ar_len}, 64'h0);
    check("t1_c1_ar_size", {61'b0, bus.ar_size}, 64'h3);
    check("t1_c1_ar_burst", {62'b0, bus.ar_burst}, 64'h1);
    tick(); #1;
    check("t1_c2_r_ready", {63'b0, bus.r_ready}, 64'd1);
    check("t1_c2_ar_valid", {63'b0, bus.ar_valid}, 64'd0);
    check("t1_c2_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t1_c3_valid", {63'b0, isram_valid}, 64'd1);
    check("t1_c3_rdata", {32'b0, isram_rdata}, 64'h0000_0093);
    check("t1_c3_stall", {63'b0, stallreq_if}, 64'd0);

    // Test 2: PC frozen for 5 cycles
    ar_base = ar_cnt;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("t2_valid", {63'b0, isram_valid}, 64'd1);
      check("t2_ar_valid", {63'b0, bus.ar_valid}, 64'd0);
    end
    check("t2_ar_count", 64'(ar_cnt - ar_base), 64'd0);

    // Test 3: PC+4 within the same beat
    tick();
    isram_addr = 64'h8000_0004;
    #1;
`ifdef IFETCH_PAIR_EN
    check("t3_pair_valid", {63'b0, isram_valid}, 64'd1);
    check("t3_pair_rdata", {32'b0, isram_rdata}, 64'h0000_0413);
    tick(); #1;
    check("t3_pair_no_ar", {63'b0, bus.ar_valid}, 64'd0);
`else
    check("t3_miss", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t3_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    check("t3_ar_addr", bus.ar_addr, 64'h8000_0000);
    wait_valid("t3_wait_valid", 10);
    check("t3_rdata", {32'b0, isram_rdata}, 64'h0000_0413);
`endif

    // Test 4: delayed ar_ready with a flush while the address is pending
    tick();
    ar_ready_en = 1'b0;
    isram_addr = 64'h8000_0040;
    #1;
    check("t4_c0_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t4_c1_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    check("t4_c1_ar_addr", bus.ar_addr, 64'h8000_0040);
    tick();
    flush = 1'b1;
    #1;
    check("t4_c2_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    tick();
    flush = 1'b0;
    isram_addr = 64'h8000_0100;
    #1;
    check("t4_c3_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    check("t4_c3_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t4_c4_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    tick();
    ar_ready_en = 1'b1;
    #1;
    check("t4_c5_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    check("t4_c5_ar_addr", bus.ar_addr, 64'h8000_0040);
    tick(); #1;
    check("t4_c6_r_ready", {63'b0, bus.r_ready}, 64'd1);
    check("t4_c6_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    check("t4_c7_valid", {63'b0, isram_valid}, 64'd0);
    check("t4_c7_rdata", {32'b0, isram_rdata}, 64'h0);
    check("t4_c7_fetch_err", {63'b0, fetch_err}, 64'd0);
    wait_valid("t4_wait_valid", 10);
    check("t4_rdata", {32'b0, isram_rdata}, 64'hCCCC_DDDD);

    // Test 5: SLVERR response
    tick();
    slave_resp = 2'b10;
    isram_addr = 64'h8000_0200;
    #1;
    check("t5_c0_valid", {63'b0, isram_valid}, 64'd0);
    tick(); #1;
    tick(); #1;
    check("t5_c2_fetch_err", {63'b0, fetch_err}, 64'd0);
    tick(); #1;
    check("t5_c3_valid", {63'b0, isram_valid}, 64'd1);
    check("t5_c3_rdata", {32'b0, isram_rdata}, 64'h0BAD_F00D);
    check("t5_c3_fetch_err", {63'b0, fetch_err}, 64'd1);
    tick(); #1;
    check("t5_c4_fetch_err", {63'b0, fetch_err}, 64'd0);
    check("t5_c4_valid", {63'b0, isram_valid}, 64'd1);
    slave_resp = 2'b00;

    // Test 6: reset while waiting for the R beat
    tick();
    r_stall = 1'b1;
    isram_addr = 64'h8000_0000;
    #1;
    tick(); #1;
    check("t6_c1_ar_valid", {63'b0, bus.ar_valid}, 64'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t6_c2_r_ready", {63'b0, bus.r_ready}, 64'd1);
    tick();
    rst = 1'b0;
    isram_e = 1'b0;
    r_stall = 1'b0;
    #1;
    check("t6_c3_ar_valid", {63'b0, bus.ar_valid}, 64'd0);
    check("t6_c3_r_ready", {63'b0, bus.r_ready}, 64'd0);
    check("t6_c3_valid", {63'b0, isram_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t6_late_r_ready", {63'b0, bus.r_ready}, 64'd0);
      check("t6_late_rdata", {32'b0, isram_rdata}, 64'h0);
      check("t6_late_fetch_err", {63'b0, fetch_err}, 64'd0);
    end
    check("t6_beat_pending", {63'b0, bus.r_valid}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
